cgia_line_fetcher: RTL and testbench
====================================

// Module: cgia_line_fetcher
// PURPOSE
//  Parametrised CGIA video fetcher, successor of the single-mode fetcher. Wishbone B3 classic read master.
//  Fetches LINE_LEN words per scanline from a frame pointer into an internal FIFO; the shifter pops from it.
//  Adds a programmable line length and FIFO flow control.
//  Sits between the CGIA timing generator (vsync/hstart strobes) and the pixel shifter.
// PARAMETERS
//  DW          16  Wishbone data width, bits (16 or 64)
//  AW          23  word address width
//  DEPTH_LOG2   4  FIFO depth = 2**DEPTH_LOG2 words
//  LEN_W        8  width of the line-length field; 1..2**LEN_W-1 words per line
// PORTS
//  clk_i        in   1          Wishbone SYSCON clock
//  reset_i      in   1          asynchronous, active-high reset
//  vsync_i      in   1          frame-start strobe: load pointer, flush FIFO, abort fetch
//  hstart_i     in   1          line-start strobe: begin fetching one line
//  base_i       in   AW         frame base word address, sampled on vsync_i
//  len_i        in   LEN_W      words per line, sampled on hstart_i
//  modulo_i     in   AW         words added to pointer at end of line (only with CGIA_FETCH_MODULO_EN)
//  adr_o        out  AW         Wishbone address
//  cyc_o        out  1          Wishbone cycle
//  stb_o        out  1          Wishbone strobe
//  ack_i        in   1          Wishbone acknowledge
//  dat_i        in   DW         Wishbone read data
//  pop_i        in   1          shifter consumes the head word
//  dat_o        out  DW         FIFO head word (valid when empty_o=0)
//  empty_o      out  1          FIFO empty
//  busy_o       out  1          line fetch in progress
//  late_o       out  1          one-cycle pulse: hstart_i arrived while busy
//  underrun_o   out  1          one-cycle pulse: pop_i while empty
// BEHAVIOUR
//  Reset: ptr=0, remain=0, FIFO empty, state IDLE; cyc_o=stb_o=busy_o=late_o=underrun_o=0, empty_o=1, adr_o=0, dat_o=0.
//  FSM states:
//   - IDLE: hstart_i with len_i!=0 -> remain<=len_i, busy_o=1, go to REQ. len_i==0 -> no-op.
//   - REQ: cyc_o=stb_o=1, adr_o=ptr. Held until ack_i.
//     On ack_i: push dat_i, ptr+=1, remain-=1.
//     remain becomes 0 -> IDLE. Otherwise next cycle REQ if FIFO has space, else STALL.
//   - STALL: cyc_o=stb_o=0. Return to REQ the cycle after FIFO has >=1 free entry.
//  REQ is entered only with >=1 free entry guaranteed. Never more than one request outstanding.
//  ack_i is ignored unless stb_o=1. Writes never issued; no sel_o.
//  Address arithmetic: ptr wraps modulo 2**AW silently.
//  FIFO:
//   - Push and pop in the same cycle: both occur, count unchanged.
//   - Pop while empty: no state change; underrun_o pulses.
//   - dat_o is registered head data. A pushed word is visible on dat_o the cycle after its ack.
//  hstart_i while busy_o=1: ignored, late_o pulses for one cycle; the fetch in progress continues.
//  vsync_i has priority over all else:
//   - ptr<=base_i, FIFO flushed, remain<=0, next state IDLE.
//   - An in-flight REQ drops cyc_o/stb_o next cycle and discards its ack.
//   - vsync_i with hstart_i in the same cycle: vsync_i wins, hstart_i is dropped (no late_o).
//  Reset asserted mid-fetch: outputs return to reset values immediately (async).
// CONFIGURATION
//  CGIA_FETCH_MODULO_EN defined:
//   - At the end of each line, ptr <= ptr + modulo_i, in the cycle of the last ack; supports windowed bitmaps.
//  Undefined:
//   - modulo_i is unused and ptr advances linearly.
// STRUCTURE
//  Shared include cgia_defs.vh: FSM state encodings (IDLE/REQ/STALL) and default DW/AW.
//  One sub-module: cgia_fetch_fifo (DW, DEPTH_LOG2).
//   - Ports: push, pop, din, dout, empty, full, count.
//   - Async reset; flush input.
//  FSM, pointer and line counter live in the top level.
// TESTING (50 MHz clk, reset held 100 ns, "@I"/"@E" display tags)
//  1. Reset -> cyc_o=0, empty_o=1, busy_o=0, adr_o=0.
//  2. vsync base=0x1000; hstart len=4; slave ack next cycle ->
//     adr_o 0x1000..0x1003, 4 words queued, busy_o falls after 4th ack, ptr=0x1004.
//  3. DEPTH_LOG2=2, len=8, no pops -> 4 acks, then stb_o=0 (STALL).
//     One pop -> exactly one more request at the next address.
//  4. hstart during busy -> late_o one cycle, line length unchanged. Pop on empty -> underrun_o one cycle.
//  5. vsync mid-REQ before ack -> cyc_o drops next cycle, empty_o=1, late ack ignored,
//     next fetch starts at the new base_i.
//  6. MODULO_EN, base=0x2000, len=4, modulo=0x10 -> line 2 starts at 0x2014.
//     Without MODULO_EN -> line 2 starts at 0x2004.

Source files
------------

// File: rtl/cgia_line_fetcher_pkg.sv
// Shared definitions for the CGIA line fetcher: FSM state encoding and
// default bus geometry used by the top level.
package cgia_line_fetcher_pkg;

    // Default Wishbone data width and word address width
    localparam int CGIA_DEFAULT_DW = 16;
    localparam int CGIA_DEFAULT_AW = 23;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STALL = 2'd2
    } fetchState_e;

endpackage

// File: rtl/cgia_fetch_fifo.sv
// Small synchronous FIFO between the Wishbone fetch side and the pixel shifter.
// The head word is held in its own register so dat_o comes straight from a
// flop; a pushed word reaches the head register the cycle after its push.
module cgia_fetch_fifo #(
    parameter int DW         = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DW-1:0]         din_i,
    output logic [DW-1:0]         dout_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [DW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DW-1:0]         dout_q, dout_d;
    logic                  isEmpty, isFull, pushEff, popEff;
    logic [DEPTH_LOG2-1:0] rdNext;

    assign isEmpty = (count_q == '0);
    assign isFull  = count_q[DEPTH_LOG2];
    assign popEff  = pop_i && !isEmpty;
    assign pushEff = push_i && (!isFull || popEff);
    assign rdNext  = rdPtr_q + DEPTH_LOG2'(1);

    // Next pointers, occupancy and head word; a flush empties everything
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
            dout_d  = '0;
        end else begin
            if (pushEff) begin
                wrPtr_d = wrPtr_q + DEPTH_LOG2'(1);
            end
            if (popEff) begin
                rdPtr_d = rdNext;
            end
            count_d = count_q + CW'(pushEff) - CW'(popEff);
            if (popEff) begin
                if (count_q == CW'(1)) begin
                    dout_d = pushEff ? din_i : '0;
                end else begin
                    dout_d = mem_q[rdNext];
                end
            end else if (isEmpty && pushEff) begin
                dout_d = din_i;
            end
        end
    end

    // Storage array, written on every accepted push
    always_ff @(posedge clk_i) begin
        if (pushEff && !flush_i) begin
            mem_q[wrPtr_q] <= din_i;
        end
    end

    // Pointer, occupancy and head registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    assign dout_o  = dout_q;
    assign empty_o = isEmpty;
    assign full_o  = isFull;
    assign count_o = count_q;

endmodule

// File: rtl/cgia_line_fetcher.sv
// CGIA line fetcher: Wishbone B3 classic read master that pulls one scanline
// of words from the frame pointer into a FIFO for the pixel shifter.
// Optional feature macro: CGIA_FETCH_MODULO_EN adds modulo_i to the pointer
// at the end of each line (windowed bitmaps); otherwise the pointer runs
// linearly and modulo_i is ignored.
module cgia_line_fetcher
    import cgia_line_fetcher_pkg::*;
#(
    parameter int DW         = CGIA_DEFAULT_DW,
    parameter int AW         = CGIA_DEFAULT_AW,
    parameter int DEPTH_LOG2 = 4,
    parameter int LEN_W      = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              vsync_i,
    input  logic              hstart_i,
    input  logic [AW-1:0]     base_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [AW-1:0]     modulo_i,
    output logic [AW-1:0]     adr_o,
    output logic              cyc_o,
    output logic              stb_o,
    input  logic              ack_i,
    input  logic [DW-1:0]     dat_i,
    input  logic              pop_i,
    output logic [DW-1:0]     dat_o,
    output logic              empty_o,
    output logic              busy_o,
    output logic              late_o,
    output logic              underrun_o
);

    localparam int CW = DEPTH_LOG2 + 1;

    fetchState_e       state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              late_q, late_d;
    logic              underrun_q, underrun_d;

    logic              reqActive, ackTaken, lastWord;
    logic              fifoPush, fifoPop, fifoEmpty, fifoFull;
    logic [CW-1:0]     fifoCount, countAfter;
    logic [AW-1:0]     ptrLineEnd;

    assign reqActive  = (state_q == ST_REQ);
    assign ackTaken   = reqActive && ack_i && !vsync_i;
    assign lastWord   = (remain_q == LEN_W'(1));
    assign fifoPush   = ackTaken;
    assign fifoPop    = pop_i && !fifoEmpty && !vsync_i;
    assign countAfter = fifoCount + CW'(fifoPush) - CW'(fifoPop);

`ifdef CGIA_FETCH_MODULO_EN
    assign ptrLineEnd = ptr_q + AW'(1) + modulo_i;
`else
    logic unusedModulo;
    assign unusedModulo = ^modulo_i;
    assign ptrLineEnd   = ptr_q + AW'(1);
`endif

    // Sequencer next state, pointer and line counter; vsync overrides everything
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        remain_d   = remain_q;
        late_d     = hstart_i && (state_q != ST_IDLE) && !vsync_i;
        underrun_d = pop_i && fifoEmpty;
        if (vsync_i) begin
            ptr_d    = base_i;
            remain_d = '0;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hstart_i && (len_i != '0)) begin
                        remain_d = len_i;
                        state_d  = fifoFull ? ST_STALL : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_i) begin
                        remain_d = remain_q - LEN_W'(1);
                        if (lastWord) begin
                            ptr_d   = ptrLineEnd;
                            state_d = ST_IDLE;
                        end else begin
                            ptr_d   = ptr_q + AW'(1);
                            state_d = countAfter[DEPTH_LOG2] ? ST_STALL : ST_REQ;
                        end
                    end
                end
                ST_STALL: begin
                    if (!fifoFull) begin
                        state_d = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state, pointer, line counter and status pulse registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            remain_q   <= '0;
            late_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            remain_q   <= remain_d;
            late_q     <= late_d;
            underrun_q <= underrun_d;
        end
    end

    cgia_fetch_fifo #(
        .DW         (DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) uFifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (vsync_i),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .din_i   (dat_i),
        .dout_o  (dat_o),
        .empty_o (fifoEmpty),
        .full_o  (fifoFull),
        .count_o (fifoCount)
    );

    assign adr_o      = ptr_q;
    assign cyc_o      = reqActive;
    assign stb_o      = reqActive;
    assign busy_o     = (state_q != ST_IDLE);
    assign empty_o    = fifoEmpty;
    assign late_o     = late_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_cgia_line_fetcher.sv
// Directed bench for cgia_line_fetcher with a 4-entry FIFO and a zero-wait
// Wishbone slave driven by hand. Inputs change on the falling edge; outputs
// are checked on the falling edge before new inputs are applied.
module tb_cgia_line_fetcher;

    localparam int DW = 16;
    localparam int AW = 23;
    localparam int LW = 8;

`ifdef CGIA_FETCH_MODULO_EN
    localparam logic [AW-1:0] MOD = 23'h10;
`else
    localparam logic [AW-1:0] MOD = 23'h0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          vsync_i, hstart_i, ack_i, pop_i;
    logic [AW-1:0] base_i, modulo_i;
    logic [LW-1:0] len_i;
    logic [DW-1:0] dat_i;
    logic [AW-1:0] adr_o;
    logic          cyc_o, stb_o, empty_o, busy_o, late_o, underrun_o;
    logic [DW-1:0] dat_o;

    int checks = 0;
    int errors = 0;

    cgia_line_fetcher #(
        .DW(DW), .AW(AW), .DEPTH_LOG2(2), .LEN_W(LW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .vsync_i(vsync_i), .hstart_i(hstart_i),
        .base_i(base_i), .len_i(len_i), .modulo_i(modulo_i), .adr_o(adr_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .dat_i(dat_i), .pop_i(pop_i),
        .dat_o(dat_o), .empty_o(empty_o), .busy_o(busy_o), .late_o(late_o),
        .underrun_o(underrun_o)
    );

    // 50 MHz clock
    always #10 clk_i = ~clk_i;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Acknowledge the request on the bus this cycle after checking its address
    task automatic applyStimulus(input string tag, input logic [AW-1:0] expAdr, input logic [DW-1:0] data);
        checkOutput({tag, "_stb"}, 64'(stb_o), 64'(1'b1));
        checkOutput({tag, "_adr"}, 64'(adr_o), 64'(expAdr));
        ack_i = 1'b1;
        dat_i = data;
        tick();
        ack_i = 1'b0;
        dat_i = '0;
    endtask

    initial begin
        reset_i = 1'b1; vsync_i = 0; hstart_i = 0; ack_i = 0; pop_i = 0;
        base_i = '0; modulo_i = '0; len_i = '0; dat_i = '0;

        // Reset values
        #50;
        checkOutput("rst_cyc", 64'(cyc_o), 64'(1'b0));
        checkOutput("rst_stb", 64'(stb_o), 64'(1'b0));
        checkOutput("rst_empty", 64'(empty_o), 64'(1'b1));
        checkOutput("rst_busy", 64'(busy_o), 64'(1'b0));
        checkOutput("rst_adr", 64'(adr_o), 64'(0));
        checkOutput("rst_dat", 64'(dat_o), 64'(0));
        #50;
        tick();
        reset_i = 1'b0;

        // Basic line of four words from 0x1000
        tick();
        vsync_i = 1; base_i = 23'h1000;
        tick();
        vsync_i = 0;
        checkOutput("t2_ptr", 64'(adr_o), 64'(23'h1000));
        hstart_i = 1; len_i = 8'd4;
        tick();
        hstart_i = 0;
        checkOutput("t2_busy", 64'(busy_o), 64'(1'b1));
        for (int i = 0; i < 4; i++)
            applyStimulus($sformatf("t2_ack%0d", i), 23'h1000 + 23'(i), 16'hA000 + 16'(i));
        checkOutput("t2_busy_end", 64'(busy_o), 64'(1'b0));
        checkOutput("t2_stb_end", 64'(stb_o), 64'(1'b0));
        checkOutput("t2_ptr_end", 64'(adr_o), 64'(23'h1004));
        checkOutput("t2_empty", 64'(empty_o), 64'(1'b0));
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t2_pop%0d", k), 64'(dat_o), 64'(16'hA000 + 16'(k)));
            pop_i = 1;
            tick();
        end
        pop_i = 0;
        checkOutput("t2_drained", 64'(empty_o), 64'(1'b1));

        // FIFO full stalls the line; each freed entry allows one more request
        hstart_i = 1; len_i = 8'd8;
        tick();
        hstart_i = 0;
        for (int i = 0; i < 4; i++)
            applyStimulus($sformatf("t3_ack%0d", i), 23'h1004 + 23'(i), 16'hB000 + 16'(i));
        checkOutput("t3_stall_stb", 64'(stb_o), 64'(1'b0));
        checkOutput("t3_stall_busy", 64'(busy_o), 64'(1'b1));
        tick();
        tick();
        checkOutput("t3_stall_hold", 64'(cyc_o), 64'(1'b0));
        checkOutput("t3_head", 64'(dat_o), 64'(16'hB000));
        pop_i = 1;
        tick();
        pop_i = 0;
        checkOutput("t3_after_pop", 64'(stb_o), 64'(1'b0));
        tick();
        applyStimulus("t3_resume", 23'h1008, 16'hB004);
        checkOutput("t3_restall", 64'(stb_o), 64'(1'b0));
        tick();
        checkOutput("t3_restall2", 64'(stb_o), 64'(1'b0));

        // vsync aborts an outstanding request and flushes the FIFO
        pop_i = 1;
        tick();
        pop_i = 0;
        tick();
        checkOutput("t5_req_stb", 64'(stb_o), 64'(1'b1));
        checkOutput("t5_req_adr", 64'(adr_o), 64'(23'h1009));
        vsync_i = 1; base_i = 23'h5000;
        tick();
        vsync_i = 0;
        checkOutput("t5_cyc_drop", 64'(cyc_o), 64'(1'b0));
        checkOutput("t5_stb_drop", 64'(stb_o), 64'(1'b0));
        checkOutput("t5_flush", 64'(empty_o), 64'(1'b1));
        checkOutput("t5_idle", 64'(busy_o), 64'(1'b0));
        checkOutput("t5_newbase", 64'(adr_o), 64'(23'h5000));
        ack_i = 1; dat_i = 16'hDEAD;
        tick();
        ack_i = 0; dat_i = '0;
        checkOutput("t5_late_ack", 64'(empty_o), 64'(1'b1));

        // Pop on an empty FIFO
        pop_i = 1;
        tick();
        pop_i = 0;
        checkOutput("t4_underrun", 64'(underrun_o), 64'(1'b1));
        tick();
        checkOutput("t4_underrun_off", 64'(underrun_o), 64'(1'b0));

        // One-word line from the new base
        hstart_i = 1; len_i = 8'd1;
        tick();
        hstart_i = 0;
        applyStimulus("t5_new", 23'h5000, 16'hBEEF);
        checkOutput("t5_new_dat", 64'(dat_o), 64'(16'hBEEF));
        checkOutput("t5_new_busy", 64'(busy_o), 64'(1'b0));
        checkOutput("t5_new_ptr", 64'(adr_o), 64'(23'h5001));
        pop_i = 1;
        tick();
        pop_i = 0;
        checkOutput("t5_new_empty", 64'(empty_o), 64'(1'b1));

        // Late hstart during a line, then line-end pointer step
        vsync_i = 1; base_i = 23'h2000; modulo_i = 23'h10;
        tick();
        vsync_i = 0;
        hstart_i = 1; len_i = 8'd4;
        tick();
        hstart_i = 1; len_i = 8'd1;
        applyStimulus("t6_ack0", 23'h2000, 16'hC000);
        hstart_i = 0;
        checkOutput("t4_late", 64'(late_o), 64'(1'b1));
        applyStimulus("t6_ack1", 23'h2001, 16'hC001);
        checkOutput("t4_late_off", 64'(late_o), 64'(1'b0));
        applyStimulus("t6_ack2", 23'h2002, 16'hC002);
        applyStimulus("t6_ack3", 23'h2003, 16'hC003);
        checkOutput("t6_busy_end", 64'(busy_o), 64'(1'b0));
        checkOutput("t6_ptr_end", 64'(adr_o), 64'(23'h2004 + MOD));
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t6_pop%0d", k), 64'(dat_o), 64'(16'hC000 + 16'(k)));
            pop_i = 1;
            tick();
        end
        pop_i = 0;
        checkOutput("t6_drained", 64'(empty_o), 64'(1'b1));
        hstart_i = 1; len_i = 8'd4;
        tick();
        hstart_i = 0;
        checkOutput("t6_line2_stb", 64'(stb_o), 64'(1'b1));
        checkOutput("t6_line2_adr", 64'(adr_o), 64'(23'h2004 + MOD));

        // vsync and hstart together: vsync wins, no late pulse
        vsync_i = 1; hstart_i = 1; base_i = 23'h6000; len_i = 8'd3;
        tick();
        vsync_i = 0; hstart_i = 0;
        checkOutput("vh_busy", 64'(busy_o), 64'(1'b0));
        checkOutput("vh_stb", 64'(stb_o), 64'(1'b0));
        checkOutput("vh_late", 64'(late_o), 64'(1'b0));
        checkOutput("vh_adr", 64'(adr_o), 64'(23'h6000));

        // Asynchronous reset in the middle of a fetch
        hstart_i = 1; len_i = 8'd2;
        tick();
        hstart_i = 0;
        checkOutput("ar_stb", 64'(stb_o), 64'(1'b1));
        #5;
        reset_i = 1;
        #1;
        checkOutput("ar_cyc", 64'(cyc_o), 64'(1'b0));
        checkOutput("ar_adr", 64'(adr_o), 64'(0));
        checkOutput("ar_busy", 64'(busy_o), 64'(1'b0));
        checkOutput("ar_empty", 64'(empty_o), 64'(1'b1));
        tick();
        reset_i = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
